// File: rtl/cache_controller.sv
// MEM-stage data cache controller: 2-way set-associative, 64-bit lines,
// write-through with invalidate-on-write and read-miss line fill from SRAM.
// Owns the tag/valid/data/LRU arrays and feeds the external hit validator.
module cache_controller #(
  parameter int unsigned SETS      = 64,
  parameter int unsigned TAG_W     = 10,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      address,
  input  logic [31:0]      wdata,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [TAG_W-1:0] tag_way0,
  output logic [TAG_W-1:0] tag_way1,
  output logic             valid_way0,
  output logic             valid_way1,
  output logic [63:0]      data_way0,
  output logic [63:0]      data_way1,
  output logic [TAG_W-1:0] tag_address,
  output logic [2:0]       offset,
  input  logic             hit,
  input  logic [31:0]      hit_data,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_wdata,
  output logic             sram_r_en,
  output logic             sram_w_en,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready
);

  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned TAG_LSB = 3 + IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR
  } state_t;

  state_t state_q, state_d;

  // Cache arrays; tag/data carry no reset, valid bits gate their use
  logic [TAG_W-1:0] tag0_q  [SETS];
  logic [TAG_W-1:0] tag1_q  [SETS];
  logic [63:0]      data0_q [SETS];
  logic [63:0]      data1_q [SETS];
  logic [SETS-1:0]  valid0_q, valid0_d;
  logic [SETS-1:0]  valid1_q, valid1_d;
  logic [SETS-1:0]  lru_q, lru_d;

  logic [31:0]      rel_addr;
  logic [IDX_W-1:0] index;
  logic             hit_way;
  logic             victim;

  // Control strobes from the output process to the array update logic
  logic fill_en;
  logic inv_en;
  logic lru_we;
  logic lru_val;

  logic unused_addr_bits;

  // Address split relative to the data-memory base
  assign rel_addr    = address - 32'(BASE_ADDR);
  assign offset      = rel_addr[2:0];
  assign index       = rel_addr[3 +: IDX_W];
  assign tag_address = rel_addr[TAG_LSB +: TAG_W];
  assign unused_addr_bits = ^rel_addr[31:TAG_LSB+TAG_W];

  // Combinational array read of the indexed set, always presented to the validator
  assign tag_way0   = tag0_q[index];
  assign tag_way1   = tag1_q[index];
  assign data_way0  = data0_q[index];
  assign data_way1  = data1_q[index];
  assign valid_way0 = valid0_q[index];
  assign valid_way1 = valid1_q[index];

  assign hit_way = valid_way1 & (tag_way1 == tag_address);
  // Prefer an empty way; only fall back to LRU when both ways are live
  assign victim  = !valid_way0 ? 1'b0 :
                   (!valid_way1 ? 1'b1 : lru_q[index]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; a store wins over a simultaneous load
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          state_d = WR;
        end else if (MEM_R_EN && !hit) begin
          state_d = RD_MISS;
        end
      end
      RD_MISS: begin
        if (sram_ready) begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (sram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and array-update strobes per state
  always_comb begin
    ready        = 1'b1;
    rdata        = '0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    fill_en      = 1'b0;
    inv_en       = 1'b0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          ready  = 1'b0;
          inv_en = hit;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata   = hit_data;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            ready = 1'b0;
          end
        end
      end
      RD_MISS: begin
        sram_r_en    = 1'b1;
        sram_address = {address[31:3], 3'b000};
        ready        = sram_ready;
        if (sram_ready) begin
          rdata   = offset[2] ? sram_rdata[63:32] : sram_rdata[31:0];
          fill_en = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~victim;
        end
      end
      WR: begin
        sram_w_en    = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        ready        = sram_ready;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  // Next valid/LRU vectors; invalidate and fill never coincide
  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    lru_d    = lru_q;
    if (inv_en) begin
      if (hit_way) begin
        valid1_d[index] = 1'b0;
      end else begin
        valid0_d[index] = 1'b0;
      end
    end
    if (fill_en) begin
      if (victim) begin
        valid1_d[index] = 1'b1;
      end else begin
        valid0_d[index] = 1'b1;
      end
    end
    if (lru_we) begin
      lru_d[index] = lru_val;
    end
  end

  // Valid and LRU state, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      lru_q    <= lru_d;
    end
  end

  // Tag and data fill into the victim way on SRAM completion
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        tag1_q[index]  <= tag_address;
        data1_q[index] <= sram_rdata;
      end else begin
        tag0_q[index]  <= tag_address;
        data0_q[index] <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus pushes expected responses
// from a set/way/LRU reference model; a negedge monitor pops and compares.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] rdata;
  logic        ready;
  logic [9:0]  tag_way0, tag_way1, tag_address;
  logic        valid_way0, valid_way1;
  logic [63:0] data_way0, data_way1;
  logic [2:0]  offset;
  logic        hit;
  logic [31:0] hit_data;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_r_en, sram_w_en;
  logic [63:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;

  always #5 clk = ~clk;

  cache_controller #(.SETS(64), .TAG_W(10), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .tag_way0(tag_way0), .tag_way1(tag_way1),
    .valid_way0(valid_way0), .valid_way1(valid_way1),
    .data_way0(data_way0), .data_way1(data_way1),
    .tag_address(tag_address), .offset(offset),
    .hit(hit), .hit_data(hit_data),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  // Environment: combinational hit validator
  logic m0, m1;
  assign m0 = valid_way0 && (tag_way0 == tag_address);
  assign m1 = valid_way1 && (tag_way1 == tag_address);
  assign hit = m0 || m1;
  assign hit_data = m1 ? (offset[2] ? data_way1[63:32] : data_way1[31:0])
                       : (offset[2] ? data_way0[63:32] : data_way0[31:0]);

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  endtask

  // Memories: reference view and the SRAM model's own contents
  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] sram_mem [int unsigned];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  // Reference cache: per set, two ways of (valid, tag) and a replace-next pointer
  bit          m_valid [64][2];
  int unsigned m_tag   [64][2];
  bit          m_lru   [64];

  typedef struct {
    bit          is_wr;
    bit          exp_stall;
    logic [31:0] exp_rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
      m_lru[s] = 1'b0;
    end
  endtask

  task automatic model_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           output exp_t e);
    int unsigned a, set, tg;
    int hw, v;
    a   = addr - 1024;
    set = (a / 8) % 64;
    tg  = (a / 512) % 1024;
    hw  = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[set][w] && m_tag[set][w] == tg) hw = w;
    e.addr = addr;
    e.wdata = wd;
    e.exp_rdata = '0;
    if (wr) begin
      e.is_wr = 1'b1;
      e.exp_stall = 1'b1;
      if (hw >= 0) m_valid[set][hw] = 1'b0;
      ref_mem[addr] = wd;
    end else begin
      e.is_wr = 1'b0;
      e.exp_rdata = ref_rd(addr);
      if (hw >= 0) begin
        e.exp_stall = 1'b0;
        m_lru[set] = (hw == 0);
      end else begin
        e.exp_stall = 1'b1;
        if (!m_valid[set][0]) v = 0;
        else if (!m_valid[set][1]) v = 1;
        else v = int'(m_lru[set]);
        m_valid[set][v] = 1'b1;
        m_tag[set][v] = tg;
        m_lru[set] = (v == 0);
      end
    end
  endtask

  // Issue one request; leave it asserted until the DUT completes it
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    bit done;
    @(posedge clk); #1;
    model_req(wr, addr, wd, e);
    sbq.push_back(e);
    MEM_R_EN = rd;
    MEM_W_EN = wr;
    address = addr;
    wdata = wd;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
    end
    if (!done) begin
      n_total++;
      n_bad++;
      $display("FAIL issue_timeout: got ready=0 expected ready=1 within 100 cycles addr=%h", addr);
      finish_run();
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  // SRAM model: fixed or random latency, one-cycle ready pulse, abandoned on reset
  int lat_fixed = 5;
  initial begin
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        sram_ready = 1'b0;
        busy = 1'b0;
      end else if (sram_ready) begin
        sram_ready = 1'b0;
        busy = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          if (sram_w_en) begin
            sram_mem[sram_address] = sram_wdata;
            sram_ready = 1'b1;
          end else if (sram_r_en) begin
            sram_rdata = {sram_rd(sram_address + 32'd4), sram_rd(sram_address)};
            sram_ready = 1'b1;
          end else begin
            busy = 1'b0;
          end
        end
      end else if (sram_r_en || sram_w_en) begin
        busy = 1'b1;
        cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(2, 6));
      end
    end
  end

  // Monitor: protocol checks while a request is pending, pop and compare on ready
  initial begin
    exp_t fe;
    bit stalled;
    bit sram_seen;
    stalled = 1'b0;
    sram_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && (MEM_R_EN || MEM_W_EN)) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_request", 1'b1, 1'b0);
        end else begin
          fe = sbq[0];
          check("sram_req_exclusive", {63'd0, sram_r_en & sram_w_en}, 64'd0);
          if (fe.is_wr) begin
            check("wr_no_sram_read", {63'd0, sram_r_en}, 64'd0);
            if (sram_w_en) begin
              sram_seen = 1'b1;
              check("wr_sram_address", {32'd0, sram_address}, {32'd0, fe.addr});
              check("wr_sram_wdata", {32'd0, sram_wdata}, {32'd0, fe.wdata});
            end
          end else begin
            check("rd_no_sram_write", {63'd0, sram_w_en}, 64'd0);
            if (sram_r_en) begin
              sram_seen = 1'b1;
              check("rd_sram_address", {32'd0, sram_address}, {32'd0, fe.addr[31:3], 3'b000});
            end
          end
          if (!ready) begin
            stalled = 1'b1;
          end else begin
            void'(sbq.pop_front());
            check(fe.is_wr ? "wr_stall" : "rd_stall", {63'd0, stalled}, {63'd0, fe.exp_stall});
            check(fe.is_wr ? "wr_sram_used" : "rd_sram_used", {63'd0, sram_seen}, {63'd0, fe.exp_stall});
            if (!fe.is_wr)
              check("rdata", {32'd0, rdata}, {32'd0, fe.exp_rdata});
            stalled = 1'b0;
            sram_seen = 1'b0;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit seen;
    ref_mem[1024]  = 32'h1111_2222;
    ref_mem[1028]  = 32'hAAAA_BBBB;
    sram_mem[1024] = 32'h1111_2222;
    sram_mem[1028] = 32'hAAAA_BBBB;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    address = 32'd1024;
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_sram_r_en", {63'd0, sram_r_en}, 64'd0);
    check("rst_sram_w_en", {63'd0, sram_w_en}, 64'd0);
    check("rst_valid0", {63'd0, valid_way0}, 64'd0);
    check("rst_valid1", {63'd0, valid_way1}, 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Cold miss to 1028, then a zero-cycle hit on the other word of the line
    issue(1, 0, 32'd1028, '0);
    issue(1, 0, 32'd1024, '0);
    // Conflict fills and LRU replacement in set 0
    issue(1, 0, 32'd1536, '0);
    issue(1, 0, 32'd1024, '0);
    issue(1, 0, 32'd2048, '0);
    issue(1, 0, 32'd1024, '0);
    issue(1, 0, 32'd1536, '0);
    idle();

    // Reset while a read miss is outstanding
    mon_en = 1'b0;
    @(posedge clk); #1;
    MEM_R_EN = 1'b1;
    address = 32'd1032;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (sram_r_en) seen = 1'b1;
    end
    check("abort_miss_started", {63'd0, seen}, 64'd1);
    check("abort_miss_addr", {32'd0, sram_address}, 64'd1032);
    check("abort_miss_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    MEM_R_EN = 1'b0;
    #1;
    check("midrst_ready", {63'd0, ready}, 64'd1);
    check("midrst_sram_r_en", {63'd0, sram_r_en}, 64'd0);
    check("midrst_sram_w_en", {63'd0, sram_w_en}, 64'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 1024 must miss again after reset, then hit
    issue(1, 0, 32'd1024, '0);
    issue(1, 0, 32'd1028, '0);
    // Write hit: write-through and invalidate; following read misses
    issue(0, 1, 32'd1024, 32'hDEAD_BEEF);
    issue(1, 0, 32'd1024, '0);
    // Write miss: SRAM only, resident line still hits
    issue(0, 1, 32'd2000, 32'h0BAD_F00D);
    issue(1, 0, 32'd1024, '0);
    issue(1, 0, 32'd2000, '0);
    // Load and store together: store path only
    issue(1, 1, 32'd1024, 32'h1234_5678);
    issue(1, 0, 32'd1024, '0);
    idle();

    // Randomized traffic over a few tags and sets to force conflicts
    lat_fixed = 0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int unsigned op;
      a = 32'd1024 + $urandom_range(0, 3) * 512 + $urandom_range(0, 1) * 8
          + $urandom_range(0, 1) * 4;
      op = $urandom_range(0, 9);
      if (op < 6) issue(1, 0, a, '0);
      else if (op < 9) issue(0, 1, a, $urandom);
      else issue(1, 1, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    finish_run();
  end

  // Watchdog
  initial begin
    #2000000;
    n_total++;
    n_bad++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    finish_run();
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequential controller for the MEM-stage 2-way set-associative data cache (64 sets × 2 ways × 64-bit lines, 10-bit tags).
- Owns the tag, valid, data and LRU arrays. Drives the combinational hit-validation stage's inputs and consumes its hit/data result.
- On a read miss it fills the line from the SRAM controller. All writes go write-through to SRAM.
- Stalls the pipeline through `ready`.

Parameters:
- SETS, 64, number of sets; index width = log2(SETS).
- TAG_W, 10, tag width.
- BASE_ADDR, 1024, data-memory base, subtracted from the incoming address.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- address  in  32  MEM-stage byte address.
- wdata  in  32  store data.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- rdata  out  32  load result.
- ready  out  1  request complete; 0 freezes the pipeline.
- tag_way0, tag_way1  out  10  tags of the indexed set, to the hit validator.
- valid_way0, valid_way1  out  1  valid bits of the indexed set.
- data_way0, data_way1  out  64  lines of the indexed set.
- tag_address  out  10  tag field of the request.
- offset  out  3  offset field of the request.
- hit  in  1  from the hit validator.
- hit_data  in  32  selected word from the hit validator.
- sram_address  out  32  line-aligned read address or word write address.
- sram_wdata  out  32  store data to SRAM.
- sram_r_en, sram_w_en  out  1  SRAM requests.
- sram_rdata  in  64  line returned by SRAM.
- sram_ready  in  1  SRAM request complete, one-cycle pulse.

Behaviour:
- Address split: a = address − BASE_ADDR.
  - offset = a[2:0]; offset[2] selects the upper word.
  - index = a[8:3].
  - tag = a[18:9].
- Array reads are combinational on the index. The hit-validator ports are always driven.
- Way-select on hit: hit_way = valid_way1 & (tag_way1 == tag).
- States: IDLE, RD_MISS, WR.
- IDLE:
  - No request: ready=1.
  - MEM_R_EN & hit: ready=1, rdata=hit_data. lru[index] <= ~hit_way. Stay in IDLE. Zero-cycle hit latency.
  - MEM_R_EN & !hit: ready=0, go to RD_MISS.
  - MEM_W_EN, hit or not: ready=0, go to WR. If hit, clear the valid bit of the hitting way on this edge (invalidate-on-write, no write-allocate).
  - Both MEM_R_EN and MEM_W_EN asserted is illegal; MEM_W_EN wins.
- RD_MISS:
  - sram_r_en=1, sram_address = {address[31:3], 3'b000}. ready=0 until sram_ready.
  - On sram_ready, victim selection: way0 if !valid_way0; else way1 if !valid_way1; else way lru[index].
  - On sram_ready, victim line <= sram_rdata, tag <= tag, valid <= 1, lru[index] <= ~victim.
  - Same cycle: ready=1, rdata = offset[2] ? sram_rdata[63:32] : sram_rdata[31:0]. Go to IDLE.
- WR:
  - sram_w_en=1, sram_address=address, sram_wdata=wdata.
  - On sram_ready: ready=1, go to IDLE. The cache contents are not modified in WR.
- The request inputs are held stable by the frozen pipeline while ready=0. The controller does not latch them.
- Back-to-back: after a fill, the next cycle re-evaluates in IDLE. The same address now hits.
- SRAM requests are deasserted in IDLE. sram_r_en and sram_w_en are never both 1.
- Reset (asynchronous, any state, including mid-miss or mid-write):
  - state=IDLE; all valid bits=0; all lru bits=0.
  - Outputs: sram_r_en=0, sram_w_en=0, ready=1 (no request).
  - An abandoned SRAM access is not completed.
- Tag and data arrays are not reset. Only valid bits gate their use.
- rdata is don't-care when ready=0 or there is no read. The bench checks it only on ready=1 with MEM_R_EN.

Test Plan:
- Reset: hold rst_n=0 mid-RD_MISS, then release. Required: state IDLE, ready=1, sram_r_en=0; a read to address 1024 then misses (valid cleared).
- Cold read miss to 1028:
  - Required: sram_r_en=1, sram_address=1024, ready=0.
  - SRAM returns 64'hAAAA_BBBB_1111_2222 after 5 cycles. Required: ready=1 that cycle, rdata=32'hAAAA_BBBB, fill into way0, lru[0]=1.
  - Next read to 1024 hits in 0 cycles with rdata=32'h1111_2222.
- Conflict fill and LRU:
  - Miss on 1024 (fills way0), then miss on 1024+512 (same set, fills way1, lru=0).
  - Read 1024 (hit, lru=1), then miss on 1024+1024. Required: way1 is replaced; 1024 still hits.
- Write hit: with 1024 resident, store 32'hDEAD_BEEF to 1024.
  - Required: sram_w_en=1, sram_address=1024, sram_wdata=32'hDEAD_BEEF, ready=0 until sram_ready; way0 invalidated.
  - A following read of 1024 misses.
- Write miss: store to 2000. Required: SRAM write only; cache arrays unchanged; no sram_r_en.
- Simultaneous MEM_R_EN and MEM_W_EN on 1024: required WR path only (sram_w_en=1, sram_r_en=0).
